// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// The master drives operands and start; the slave returns status and results.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, with divide-by-zero and quotient-overflow detection.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    // Partial remainder keeps only W bits: after each restoring step it is
    // below the divisor, so its top bit is always zero.
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  low_q, low_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dbz_q, dbz_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH:0]    trial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            low_q   <= '0;
            quot_q  <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            low_q   <= low_d;
            quot_q  <= quot_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        low_d   = low_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        trial   = {rem_q, low_q[WIDTH-1]};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dvs_d  = bus.divisor;
                    low_d  = bus.dividend[WIDTH-1:0];
                    rem_d  = bus.dividend[2*WIDTH-1:WIDTH];
                    quot_d = '0;
                    cnt_d  = CW'(WIDTH);
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b0;
                    if (bus.divisor == '0) begin
                        dbz_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end else if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
                        ovf_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (trial >= {1'b0, dvs_q}) begin
                    rem_d  = trial[WIDTH-1:0] - dvs_q;
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = trial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                low_d = {low_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: an arithmetic reference model checked
// every cycle, plus literal expectations for each handshake scenario.
module tb_seq_divider;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_en = 1'b0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: operation-level timing and plain division.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_dbz  = 1'b0;
    bit          m_ovf  = 1'b0;
    logic [W-1:0] m_q   = '0;
    logic [W-1:0] m_r   = '0;
    int          m_left = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_ovf = 1'b0;
            m_q = '0; m_r = '0; m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1'b1;
        end else if (bus.start) begin
            logic [63:0] dvd;
            logic [63:0] dvs;
            dvd = bus.dividend;
            dvs = {32'd0, bus.divisor};
            m_busy = 1'b1;
            m_dbz  = (dvs == 0);
            m_ovf  = (dvs != 0) && ((dvd >> W) >= dvs);
            if (m_dbz || m_ovf) begin
                m_q = '1;
                m_r = '0;
                m_done = 1'b1;
            end else begin
                m_q = W'(dvd / dvs);
                m_r = W'(dvd % dvs);
                m_left = W;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {63'd0, bus.busy}, {63'd0, m_busy});
            chk("done", {63'd0, bus.done}, {63'd0, m_done});
            chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, m_dbz});
            chk("overflow", {63'd0, bus.overflow}, {63'd0, m_ovf});
            if (!m_busy || m_done) begin
                chk("quotient", {32'd0, bus.quotient}, {32'd0, m_q});
                chk("remainder", {32'd0, bus.remainder}, {32'd0, m_r});
            end
        end
    end

    // Issue one start, wait (bounded) for done, check latency and literal results.
    task automatic run_case(input string tag, input logic [63:0] dvd, input logic [31:0] dvs,
                            input logic [31:0] eq, input logic [31:0] er,
                            input bit edbz, input bit eovf, input int elat);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            bus.start = 1'b0; bus.dividend = ~dvd; bus.divisor = ~dvs;
        end while (!bus.done && n < 100);
        chk({tag, "_latency"}, n, elat);
        chk({tag, "_q"}, {32'd0, bus.quotient}, {32'd0, eq});
        chk({tag, "_r"}, {32'd0, bus.remainder}, {32'd0, er});
        chk({tag, "_flags"}, {62'd0, bus.div_by_zero, bus.overflow}, {62'd0, edbz, eovf});
        chk({tag, "_model_q"}, {32'd0, m_q}, {32'd0, eq});
        @(posedge clk); #1;
        chk({tag, "_busy_drop"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder[27:0]}, 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        run_case("c1", 64'd10210000000, 32'd1021, 32'd10000000, 32'd0, 1'b0, 1'b0, W + 1);
        run_case("c2", 64'd11682704, 32'd3413, 32'd3423, 32'd5, 1'b0, 1'b0, W + 1);
        run_case("c3", 64'hFFFFFFFE00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, W + 1);
        run_case("c4z", 64'd12345, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1);
        run_case("c4o", 64'h0000000500000000, 32'd5, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1);

        // Starts during RUN and during the done cycle must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 64'd11682704; bus.divisor = 32'd3413;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.dividend = 64'd999; bus.divisor = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("c5_done_seen", {63'd0, bus.done}, 64'd1);
        bus.start = 1'b1; bus.dividend = 64'd100; bus.divisor = 32'd3;
        chk("c5_q", {32'd0, bus.quotient}, 64'd3423);
        chk("c5_r", {32'd0, bus.remainder}, 64'd5);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("c5_idle", {63'd0, bus.busy}, 64'd0);
        run_case("c5b", 64'hFFFFFFFE00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, W + 1);

        // Reset mid-run aborts the division.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 64'd10210000000; bus.divisor = 32'd1021;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("c6_rst_outs", {bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder[27:0]}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("c6_no_done", {62'd0, bus.busy, bus.done}, 64'd0);
        run_case("c6b", 64'd11682704, 32'd3413, 32'd3423, 32'd5, 1'b0, 1'b0, W + 1);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
